pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/pipe_fwd_unit.sv | 34 +++
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/halt controller: FSM encoding,
// forwarding select codes, drain length and small helper functions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [1:0]  FWD_RF = 2'd0;
    localparam logic [1:0]  FWD_ME = 2'd1;
    localparam logic [1:0]  FWD_WB = 2'd2;

    localparam int          DRAIN_CYCLES = 3;
    localparam logic [1:0]  DRAIN_INIT   = 2'(DRAIN_CYCLES);
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    // Per-cycle pipeline steering, packed MSB first.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN      = 4'b1100;
    localparam pipe_ctl_t CTL_REDIRECT = 4'b1111;
    localparam pipe_ctl_t CTL_STALL    = 4'b0001;
    localparam pipe_ctl_t CTL_HOLD     = 4'b0000;
    localparam pipe_ctl_t CTL_FLUSH    = 4'b0011;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic we);
        return we && (src == dst) && (src != 5'd0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX operand bypass selection: the youngest producer (ME) wins over WB.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_ex_i,
    input  logic [4:0] rt_ex_i,
    input  logic [4:0] rw_me_i,
    input  logic       regwrite_me_i,
    input  logic [4:0] rw_wb_i,
    input  logic       regwrite_wb_i,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o
);

    logic a_me, a_wb, b_me, b_wb;

    assign a_me = reg_match(rs_ex_i, rw_me_i, regwrite_me_i);
    assign a_wb = reg_match(rs_ex_i, rw_wb_i, regwrite_wb_i);
    assign b_me = reg_match(rt_ex_i, rw_me_i, regwrite_me_i);
    assign b_wb = reg_match(rt_ex_i, rw_wb_i, regwrite_wb_i);

    always_comb begin
        fwd_a_sel_o = FWD_RF;
        if (a_me)      fwd_a_sel_o = FWD_ME;
        else if (a_wb) fwd_a_sel_o = FWD_WB;
    end

    always_comb begin
        fwd_b_sel_o = FWD_RF;
        if (b_me)      fwd_b_sel_o = FWD_ME;
        else if (b_wb) fwd_b_sel_o = FWD_WB;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hazard stall, redirect flush, halt drain FSM, event
// counters. Define PIPE_CTRL_FORWARD_EN for bypassing with load-use stalls only.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        RST,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rw_ex,
    input  logic [4:0]  rw_me,
    input  logic [4:0]  rw_wb,
    input  logic        regwrite_ex,
    input  logic        regwrite_me,
    input  logic        regwrite_wb,
    input  logic        memtoreg_ex,
    input  logic        redirect_ex,
    input  logic        halt_id,
    input  logic        go,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    state_e      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    pipe_ctl_t   ctl;
    logic        is_halted;
    logic        hazard;

`ifdef PIPE_CTRL_FORWARD_EN
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // With bypassing only a load in EX cannot feed the ID instruction in time.
    assign hazard = memtoreg_ex &&
                    ((use_rs_id && reg_match(rs_id, rw_ex, regwrite_ex)) ||
                     (use_rt_id && reg_match(rt_id, rw_ex, regwrite_ex)));

    pipe_fwd_unit u_fwd (
        .rs_ex_i       (rs_ex),
        .rt_ex_i       (rt_ex),
        .rw_me_i       (rw_me),
        .regwrite_me_i (regwrite_me),
        .rw_wb_i       (rw_wb),
        .regwrite_wb_i (regwrite_wb),
        .fwd_a_sel_o   (fwd_a_raw),
        .fwd_b_sel_o   (fwd_b_raw)
    );

    assign fwd_a_sel = RST ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel = RST ? FWD_RF : fwd_b_raw;
`else
    logic src_rs_hit, src_rt_hit;
    logic unused_fwd_inputs;

    // Full interlock: wait until every in-flight producer has written back.
    assign src_rs_hit = reg_match(rs_id, rw_ex, regwrite_ex) ||
                        reg_match(rs_id, rw_me, regwrite_me) ||
                        reg_match(rs_id, rw_wb, regwrite_wb);
    assign src_rt_hit = reg_match(rt_id, rw_ex, regwrite_ex) ||
                        reg_match(rt_id, rw_me, regwrite_me) ||
                        reg_match(rt_id, rw_wb, regwrite_wb);
    assign hazard     = (use_rs_id && src_rs_hit) || (use_rt_id && src_rt_hit);

    assign fwd_a_sel         = FWD_RF;
    assign fwd_b_sel         = FWD_RF;
    assign unused_fwd_inputs = ^{rs_ex, rt_ex, memtoreg_ex};
`endif

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ctl         = CTL_RUN;
        is_halted   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_ex) begin
                    ctl         = CTL_REDIRECT;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                end else if (hazard) begin
                    ctl         = CTL_STALL;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end else if (halt_id) begin
                    // Halting instruction proceeds into EX; fetch freezes behind it.
                    ctl     = CTL_HOLD;
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                ctl = CTL_FLUSH;
                // Leave as the counter reaches zero: exactly DRAIN_CYCLES drain cycles.
                if (drain_q <= 2'd1) begin
                    drain_d = 2'd0;
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            ST_HALTED: begin
                ctl       = CTL_HOLD;
                is_halted = 1'b1;
                if (go) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = 2'd0;
            end
        endcase
        if (RST) begin
            ctl       = CTL_FLUSH;
            is_halted = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            drain_q     <= 2'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;
    assign halted      = is_halted;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations each cycle,
// monitor pops and compares after outputs settle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, rw_ex, rw_me, rw_wb;
    logic        use_rs_id, use_rt_id, regwrite_ex, regwrite_me, regwrite_wb;
    logic        memtoreg_ex, redirect_ex, halt_id, go;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .RST(RST),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rw_ex(rw_ex), .rw_me(rw_me), .rw_wb(rw_wb),
        .regwrite_ex(regwrite_ex), .regwrite_me(regwrite_me), .regwrite_wb(regwrite_wb),
        .memtoreg_ex(memtoreg_ex), .redirect_ex(redirect_ex), .halt_id(halt_id), .go(go),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
        logic [1:0]  fa, fb;
        logic [31:0] stall, flush;
    } exp_t;

    typedef enum {M_RUN, M_DRAIN, M_HALT} mode_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    mode_t       m_mode = M_RUN;
    int          m_left = 0;
    longint      m_stall = 0, m_flush = 0;
    bit          fwd_build;

    function automatic bit hit(logic [4:0] a, logic [4:0] b, logic we);
        return we && (a == b) && (a != 0);
    endfunction

    function automatic longint bump(longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    // Reference model for the current cycle; then advance to the next cycle.
    task automatic apply();
        exp_t e;
        bit   haz;
        e.fa = 0; e.fb = 0; e.halted = 0;
        if (fwd_build) begin
            haz = memtoreg_ex && ((use_rs_id && hit(rs_id, rw_ex, regwrite_ex)) ||
                                  (use_rt_id && hit(rt_id, rw_ex, regwrite_ex)));
            e.fa = hit(rs_ex, rw_me, regwrite_me) ? 2'd1 : hit(rs_ex, rw_wb, regwrite_wb) ? 2'd2 : 2'd0;
            e.fb = hit(rt_ex, rw_me, regwrite_me) ? 2'd1 : hit(rt_ex, rw_wb, regwrite_wb) ? 2'd2 : 2'd0;
        end else begin
            haz = 0;
            foreach (rw_ex[i]) ; // keeps loop-free style; stages checked below
            if (use_rs_id && (hit(rs_id, rw_ex, regwrite_ex) || hit(rs_id, rw_me, regwrite_me) ||
                              hit(rs_id, rw_wb, regwrite_wb))) haz = 1;
            if (use_rt_id && (hit(rt_id, rw_ex, regwrite_ex) || hit(rt_id, rw_me, regwrite_me) ||
                              hit(rt_id, rw_wb, regwrite_wb))) haz = 1;
        end
        if (RST) begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0011;
            e.fa = 0; e.fb = 0;
            m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
            e.stall = 0; e.flush = 0;
        end else begin
            e.stall = m_stall[31:0];
            e.flush = m_flush[31:0];
            case (m_mode)
                M_RUN: begin
                    if (redirect_ex) begin
                        {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b1111;
                        m_flush = bump(m_flush);
                    end else if (haz) begin
                        {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0001;
                        m_stall = bump(m_stall);
                    end else if (halt_id) begin
                        {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0000;
                        m_mode = M_DRAIN; m_left = 3;
                    end else begin
                        {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b1100;
                    end
                end
                M_DRAIN: begin
                    {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0011;
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
                default: begin
                    {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0000;
                    e.halted = 1;
                    if (go) m_mode = M_RUN;
                end
            endcase
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        RST = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        rs_ex = 0; rt_ex = 0; rw_ex = 0; rw_me = 0; rw_wb = 0;
        regwrite_ex = 0; regwrite_me = 0; regwrite_wb = 0;
        memtoreg_ex = 0; redirect_ex = 0; halt_id = 0; go = 0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle once inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en",       32'(pc_en),       32'(e.pc_en));
                chk("if_id_en",    32'(if_id_en),    32'(e.if_id_en));
                chk("if_id_flush", 32'(if_id_flush), 32'(e.if_id_flush));
                chk("id_ex_flush", 32'(id_ex_flush), 32'(e.id_ex_flush));
                chk("fwd_a_sel",   32'(fwd_a_sel),   32'(e.fa));
                chk("fwd_b_sel",   32'(fwd_b_sel),   32'(e.fb));
                chk("halted",      32'(halted),      32'(e.halted));
                chk("stall_cnt",   stall_cnt,        e.stall);
                chk("flush_cnt",   flush_cnt,        e.flush);
            end
        end
    end

    initial begin
`ifdef PIPE_CTRL_FORWARD_EN
        fwd_build = 1;
`else
        fwd_build = 0;
`endif
        idle(); RST = 1;
        @(negedge clk);
        idle(); RST = 1; apply(); apply();
        idle(); apply(); apply();

        // Load-use: lw $8 in EX, ID add reads $8, then pipeline advances.
        idle(); memtoreg_ex = 1; regwrite_ex = 1; rw_ex = 8; rs_id = 8; use_rs_id = 1; apply();
        idle(); regwrite_me = 1; rw_me = 8; rs_id = 8; use_rs_id = 1; apply();
        idle(); regwrite_wb = 1; rw_wb = 8; rs_ex = 8; apply();
        idle(); apply();

        // ALU producer $8 walking EX->ME->WB while ID reads rt=$8.
        idle(); regwrite_ex = 1; rw_ex = 8; rt_id = 8; use_rt_id = 1; apply();
        idle(); regwrite_me = 1; rw_me = 8; rt_id = 8; use_rt_id = 1; rt_ex = 3; apply();
        idle(); regwrite_wb = 1; rw_wb = 8; rt_id = 8; use_rt_id = 1; apply();
        idle(); rt_id = 8; use_rt_id = 1; apply();
        // $0 destination never interlocks.
        idle(); regwrite_ex = 1; memtoreg_ex = 1; regwrite_me = 1; regwrite_wb = 1;
        rs_id = 0; rt_id = 0; use_rs_id = 1; use_rt_id = 1; apply();

        // Redirect beats hazard in the same cycle.
        idle(); memtoreg_ex = 1; regwrite_ex = 1; rw_ex = 4; rs_id = 4; use_rs_id = 1;
        redirect_ex = 1; apply();

        // Halt, drain (redirect ignored), halted, go early ignored, resume.
        idle(); halt_id = 1; apply();
        idle(); redirect_ex = 1; apply();
        idle(); go = 1; apply();
        idle(); apply();
        idle(); apply(); apply();
        idle(); go = 1; apply();
        idle(); apply();

        // Reset in the middle of a drain.
        idle(); halt_id = 1; apply();
        idle(); apply();
        idle(); RST = 1; apply();
        idle(); apply(); apply(); apply();

        // Randomized traffic with small register range to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
            rs_ex = 5'($urandom_range(0, 3)); rt_ex = 5'($urandom_range(0, 3));
            rw_ex = 5'($urandom_range(0, 3)); rw_me = 5'($urandom_range(0, 3));
            rw_wb = 5'($urandom_range(0, 3));
            use_rs_id = 1'($urandom); use_rt_id = 1'($urandom);
            regwrite_ex = 1'($urandom); regwrite_me = 1'($urandom); regwrite_wb = 1'($urandom);
            memtoreg_ex = 1'($urandom);
            redirect_ex = ($urandom_range(0, 7) == 0);
            halt_id     = ($urandom_range(0, 15) == 0);
            go          = ($urandom_range(0, 3) == 0);
            RST         = ($urandom_range(0, 99) < 2);
            apply();
        end

        // Saturation: preload stall counter near the top, then keep stalling.
        idle(); RST = 1; apply();
        idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        m_stall = 64'hFFFF_FFFD;
        #1;
        apply();
        release dut.stall_cnt_q;
        for (int i = 0; i < 4; i++) begin
            idle(); memtoreg_ex = 1; regwrite_ex = 1; rw_ex = 5; rs_id = 5; use_rs_id = 1;
            apply();
        end
        idle(); apply();

        @(negedge clk); @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
